// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds bytes from four requesters to a single UART byte transmitter.
// Optional WAIT-state timeout abort is enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 32'd1_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  input  logic [2:0]  baud_cfg,
  output logic [3:0]  ack,
  output logic        busy,
  output logic [1:0]  cur_id,
  output logic [7:0]  tx_data,
  output logic        tx_send_en,
  output logic [2:0]  tx_baud_set,
  input  logic        tx_done,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    ACK  = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic [1:0]  ptr_r, ptr_s;
  logic [1:0]  grant_s;
  logic [1:0]  cur_id_s;
  logic [7:0]  tx_data_s;
  logic [2:0]  tx_baud_s;
  logic [3:0]  ack_s;
  logic        send_s;
  logic        busy_s;
  logic        timeout_s;

  // First set request bit at or above p, wrapping modulo 4; the lowest offset wins.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] pick;
    logic [1:0] idx;
    pick = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + k[1:0];
      if (r[idx]) begin
        pick = idx;
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 32'd1) ? $clog2(TIMEOUT_CYC + 32'd1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYC - 32'd1);
  logic [CNT_W-1:0] cnt_r;
`else
  logic cfg_unused_s;
  assign cfg_unused_s = (TIMEOUT_CYC == 32'd0);
`endif

  assign grant_s = rr_pick(req, ptr_r);

  // Next-state and next-output computation for the arbitration FSM.
  always_comb begin
    state_s   = state_r;
    ptr_s     = ptr_r;
    cur_id_s  = cur_id;
    tx_data_s = tx_data;
    tx_baud_s = tx_baud_set;
    ack_s     = 4'b0000;
    send_s    = 1'b0;
    timeout_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (|req) begin
          state_s   = SEND;
          cur_id_s  = grant_s;
          tx_data_s = req_data[{grant_s, 3'b000} +: 8];
          tx_baud_s = baud_cfg;
          send_s    = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      SEND: begin
        state_s = WAIT;
      end
      WAIT: begin
        // tx_done beats a coincident timeout so a finished byte is always acknowledged.
        if (tx_done) begin
          state_s = ACK;
          ack_s   = 4'b0001 << cur_id;
        end else begin
`ifdef UART_TX_ARB_TIMEOUT_EN
          if (cnt_r == CNT_LIM) begin
            state_s   = IDLE;
            ptr_s     = cur_id + 2'd1;
            timeout_s = 1'b1;
          end else begin
            state_s = WAIT;
          end
`else
          state_s = WAIT;
`endif
        end
      end
      ACK: begin
        state_s = IDLE;
        ptr_s   = cur_id + 2'd1;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State, round-robin pointer and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      ptr_r       <= 2'd0;
      ack         <= 4'b0000;
      busy        <= 1'b0;
      cur_id      <= 2'd0;
      tx_data     <= 8'h00;
      tx_send_en  <= 1'b0;
      tx_baud_set <= 3'd0;
    end else begin
      state_r     <= state_s;
      ptr_r       <= ptr_s;
      ack         <= ack_s;
      busy        <= busy_s;
      cur_id      <= cur_id_s;
      tx_data     <= tx_data_s;
      tx_send_en  <= send_s;
      tx_baud_set <= tx_baud_s;
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  // WAIT-cycle counter, cleared while the start pulse is out so it reads 0 on WAIT entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r       <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= timeout_s;
      if (state_r == SEND) begin
        cnt_r <= '0;
      end else if (state_r == WAIT) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end
`else
  logic timeout_unused_s;
  assign timeout_unused_s = timeout_s;
  assign timeout_err      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: transaction-level reference model, per-cycle compare,
// directed scenarios with literal expectations and a randomized soak.
module tb_uart_tx_arbiter;

  localparam int TCYC = 50;
`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [2:0]  baud_cfg;
  logic [3:0]  ack;
  logic        busy;
  logic [1:0]  cur_id;
  logic [7:0]  tx_data;
  logic        tx_send_en;
  logic [2:0]  tx_baud_set;
  logic        tx_done;
  logic        timeout_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.TIMEOUT_CYC(TCYC)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data), .baud_cfg(baud_cfg),
    .ack(ack), .busy(busy), .cur_id(cur_id), .tx_data(tx_data), .tx_send_en(tx_send_en),
    .tx_baud_set(tx_baud_set), .tx_done(tx_done), .timeout_err(timeout_err)
  );

  int checks = 0;
  int errors = 0;
  int glog[$];
  int ack_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one transfer at a time (granted -> waiting -> acknowledged).
  int       m_ptr = 0;
  bit       m_txn = 0;
  int       m_phase = 0;
  int       m_waits = 0;
  int       m_id = 0;
  int       m_data = 0;
  int       m_baud = 0;
  logic [3:0] e_ack = 4'b0;
  bit       e_send = 0, e_busy = 0, e_terr = 0;

  task automatic model_reset();
    m_ptr = 0; m_txn = 0; m_phase = 0; m_waits = 0;
    m_id = 0; m_data = 0; m_baud = 0;
    e_ack = 4'b0; e_send = 0; e_busy = 0; e_terr = 0;
  endtask

  task automatic model_step();
    int idx;
    bit found;
    e_send = 0; e_ack = 4'b0; e_terr = 0;
    if (!m_txn) begin
      found = 0;
      for (int k = 0; k < 4; k++) begin
        idx = (m_ptr + k) % 4;
        if (req[idx] && !found) begin
          found = 1;
          m_id = idx;
        end
      end
      if (found) begin
        m_txn = 1; m_phase = 0;
        m_data = int'(req_data[8*m_id +: 8]);
        m_baud = int'(baud_cfg);
        e_send = 1;
      end
    end else if (m_phase == 0) begin
      m_phase = 1; m_waits = 0;
    end else if (m_phase == 1) begin
      if (tx_done) begin
        e_ack = 4'(1 << m_id);
        m_phase = 2;
      end else begin
        m_waits++;
        if (TO_EN && m_waits == TCYC) begin
          e_terr = 1; m_txn = 0; m_ptr = (m_id + 1) % 4;
        end
      end
    end else begin
      m_txn = 0; m_ptr = (m_id + 1) % 4;
    end
    e_busy = m_txn;
  endtask

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (reset_n !== 1'b1) model_reset();
    else model_step();
  end

  // Compare process: every cycle out of reset, on the falling edge.
  initial forever begin
    @(negedge clk);
    if (reset_n === 1'b1) begin
      chk("ack", ack, e_ack);
      chk("busy", busy, e_busy);
      chk("tx_send_en", tx_send_en, e_send);
      chk("cur_id", cur_id, m_id);
      chk("tx_data", tx_data, m_data);
      chk("tx_baud_set", tx_baud_set, m_baud);
      chk("timeout_err", timeout_err, e_terr);
      if (tx_send_en === 1'b1) glog.push_back(int'(cur_id));
      if (ack !== 4'b0) ack_cnt++;
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cur_id"}, cur_id, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_send"}, tx_send_en, 0);
    chk({tag, "_baud"}, tx_baud_set, 0);
    chk({tag, "_terr"}, timeout_err, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_send(input int maxc, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (tx_send_en !== 1'b1 && lat < maxc);
    chk("send_seen", tx_send_en, 1);
  endtask

  // Pulse tx_done after n wait cycles; returns in the ACK cycle with req updated to next_req.
  task automatic finish_byte(input int n, input logic [3:0] exp_ack, input logic [3:0] next_req);
    repeat (n) @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("ack_after_done", ack, exp_ack);
    req = next_req;
  endtask

  int lat;
  int acks0;

  initial begin
    reset_n = 1'b0; req = 4'b0; req_data = 32'h0; baud_cfg = 3'd0; tx_done = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("por");
    reset_n = 1'b1;

    // Single requester, long transmit time.
    @(negedge clk);
    req = 4'b0100; req_data = 32'h00A5_0000; baud_cfg = 3'd2;
    wait_send(20, lat);
    chk("single_latency", lat, 1);
    chk("single_data", tx_data, 8'hA5);
    chk("single_id", cur_id, 2);
    finish_byte(99, 4'b0100, 4'b0000);
    @(negedge clk);
    chk("single_ack_clear", ack, 0);

    // Spurious completion in IDLE.
    repeat (2) @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    @(negedge clk);
    chk("spurious_busy", busy, 0);
    chk("spurious_ack", ack, 0);

    // Contention from reset: strict round robin.
    do_reset();
    glog.delete();
    acks0 = ack_cnt;
    req = 4'b1111; req_data = 32'h4433_2211;
    for (int i = 0; i < 5; i++) begin
      wait_send(10, lat);
      finish_byte(3, 4'(1 << (i % 4)), (i == 4) ? 4'b0000 : 4'b1111);
    end
    @(negedge clk);
    chk("rr_count", glog.size(), 5);
    for (int i = 0; i < 5 && i < glog.size(); i++) chk("rr_order", glog[i], i % 4);
    chk("rr_acks", ack_cnt - acks0, 5);

    // Baud latched only at grant.
    @(negedge clk);
    req = 4'b0001; baud_cfg = 3'd0; req_data = 32'h0000_003C;
    wait_send(10, lat);
    repeat (2) @(negedge clk);
    baud_cfg = 3'd4;
    repeat (3) @(negedge clk);
    chk("baud_hold", tx_baud_set, 0);
    finish_byte(1, 4'b0001, 4'b0010);
    wait_send(10, lat);
    chk("baud_new", tx_baud_set, 4);
    finish_byte(2, 4'b0010, 4'b0000);

    // Reset mid-transfer with cur_id=1.
    do_reset();
    req = 4'b0011;
    wait_send(10, lat);
    chk("abort_first", cur_id, 0);
    finish_byte(2, 4'b0001, 4'b0010);
    wait_send(10, lat);
    chk("abort_grant1", cur_id, 1);
    repeat (3) @(negedge clk);
    #2;
    reset_n = 1'b0;
    req = 4'b1001;
    #1;
    check_zero("abort");
    @(negedge clk);
    reset_n = 1'b1;
    wait_send(10, lat);
    chk("abort_restart_id", cur_id, 0);
    finish_byte(2, 4'b0001, 4'b0000);

    // WAIT timeout (or indefinite wait when the feature is built out).
    @(negedge clk);
    req = 4'b0100; req_data = 32'h0077_0000;
    wait_send(10, lat);
`ifdef UART_TX_ARB_TIMEOUT_EN
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (timeout_err !== 1'b1 && lat < 200);
    chk("timeout_latency", lat, TCYC + 1);
    chk("timeout_no_ack", ack, 0);
    req = 4'b1100;
    wait_send(10, lat);
    chk("timeout_next_id", cur_id, 3);
    finish_byte(2, 4'b1000, 4'b0000);
`else
    repeat (TCYC + 10) @(negedge clk);
    chk("no_timeout_busy", busy, 1);
    finish_byte(0, 4'b0100, 4'b0000);
`endif

    // Randomized soak against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      req_data = $urandom();
      baud_cfg = 3'($urandom_range(0, 7));
      tx_done = ($urandom_range(0, 7) == 0);
    end
    tx_done = 1'b0;
    req = 4'b0;
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
